retire_stage: RTL and testbench

- In-order commit stage directly downstream of the reorder buffer.
- Tracks per-ROB-entry completion from the complete stage and inspects the oldest N ROB entries each cycle.
- Tells the ROB how many entries to pop (num_retiring), frees old physical registers to the freelist and updates the architectural map table.
- Raises a one-cycle flush on a retiring mispredicted branch and halts the core after a halt instruction commits.

---
 rtl/retire_if.sv | 46 ++++
 rtl/retire_stage.sv | 119 +++++++++++
 tb/tb_retire_stage.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/retire_if.sv
// Retire-stage bus: ROB head window and completion strobes in, commit/free/flush/halt status out.
// The ROB-exit packet type lives here so the stage and its driver share one layout.
interface retire_if #(
    parameter int N         = 3,
    parameter int ROB_SZ    = 32,
    parameter int PHYS_BITS = 6
);
    localparam int RB = $clog2(ROB_SZ);
    localparam int SB = $clog2(N + 1);

    typedef struct packed {
        logic                 halt;
        logic                 is_branch;
        logic [4:0]           arch_dest;
        logic [PHYS_BITS-1:0] t_new;
        logic [PHYS_BITS-1:0] t_old;
    } rob_exit_packet_t;

    rob_exit_packet_t [N-1:0]       rob_outputs;
    logic [SB-1:0]                  rob_outputs_valid;
    logic [N-1:0]                   complete_valid;
    logic [N-1:0][RB-1:0]           complete_rob_idx;
    logic [N-1:0]                   complete_mispredict;

    logic [SB-1:0]                  num_retiring;
    logic [N-1:0]                   free_valid;
    logic [N-1:0][PHYS_BITS-1:0]    free_preg;
    logic [N-1:0]                   amt_valid;
    logic [N-1:0][4:0]              amt_arch;
    logic [N-1:0][PHYS_BITS-1:0]    amt_preg;
    logic                           mispredict_flush;
    logic                           halted;
    logic [63:0]                    retired_count;

    modport master (
        output rob_outputs, rob_outputs_valid, complete_valid, complete_rob_idx, complete_mispredict,
        input  num_retiring, free_valid, free_preg, amt_valid, amt_arch, amt_preg,
               mispredict_flush, halted, retired_count
    );

    modport slave (
        input  rob_outputs, rob_outputs_valid, complete_valid, complete_rob_idx, complete_mispredict,
        output num_retiring, free_valid, free_preg, amt_valid, amt_arch, amt_preg,
               mispredict_flush, halted, retired_count
    );
endinterface

// File: rtl/retire_stage.sv
// In-order commit stage: tracks completion per ROB slot, retires up to N oldest entries per cycle,
// frees old mappings, updates the architectural map, flushes on mispredicts and stops on halt.
module retire_stage #(
    parameter int N         = 3,
    parameter int ROB_SZ    = 32,
    parameter int PHYS_BITS = 6
) (
    input logic     clock,
    input logic     reset,
    retire_if.slave bus
);
    localparam int RB = $clog2(ROB_SZ);
    localparam int SB = $clog2(N + 1);

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state;
    logic [RB-1:0]     head;
    logic [ROB_SZ-1:0] complete_bits;
    logic [ROB_SZ-1:0] mispred_bits;
    logic [63:0]       count_q;

    logic [ROB_SZ-1:0]           retire_mask, set_mask, set_mp_mask;
    logic [SB-1:0]               n_ret;
    logic                        flush, halt_hit;
    logic [N-1:0]                free_v, amt_v;
    logic [N-1:0][PHYS_BITS-1:0] free_p, amt_p;
    logic [N-1:0][4:0]           amt_a;
    logic                        unused_is_branch;

    // Oldest-first scan; go drops at the first incomplete lane and after a lane that ends the group.
    always_comb begin
        logic          go;
        logic [RB-1:0] idx;
        go          = (state == RUN) && !reset;
        idx         = '0;
        n_ret       = '0;
        flush       = 1'b0;
        halt_hit    = 1'b0;
        retire_mask = '0;
        free_v      = '0;
        amt_v       = '0;
        free_p      = '0;
        amt_p       = '0;
        amt_a       = '0;
        for (int i = 0; i < N; i++) begin
            idx = head + RB'(i);
            if (go && (SB'(i) < bus.rob_outputs_valid) && complete_bits[idx]) begin
                n_ret            = n_ret + 1'b1;
                retire_mask[idx] = 1'b1;
                if (bus.rob_outputs[i].arch_dest != 5'd0) begin
                    free_v[i] = 1'b1;
                    amt_v[i]  = 1'b1;
                    free_p[i] = bus.rob_outputs[i].t_old;
                    amt_p[i]  = bus.rob_outputs[i].t_new;
                    amt_a[i]  = bus.rob_outputs[i].arch_dest;
                end
                flush    = flush | mispred_bits[idx];
                halt_hit = halt_hit | bus.rob_outputs[i].halt;
                if (mispred_bits[idx] || bus.rob_outputs[i].halt) go = 1'b0;
            end else begin
                go = 1'b0;
            end
        end
    end

    always_comb begin
        set_mask    = '0;
        set_mp_mask = '0;
        if (state == RUN) begin
            for (int i = 0; i < N; i++) begin
                if (bus.complete_valid[i]) begin
                    set_mask[bus.complete_rob_idx[i]] = 1'b1;
                    if (bus.complete_mispredict[i]) set_mp_mask[bus.complete_rob_idx[i]] = 1'b1;
                end
            end
        end
    end

    // The branch-type bit is not needed here; the mispredict bit already implies a branch.
    always_comb begin
        unused_is_branch = 1'b0;
        for (int i = 0; i < N; i++) unused_is_branch = unused_is_branch ^ bus.rob_outputs[i].is_branch;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RUN;
            head          <= '0;
            complete_bits <= '0;
            mispred_bits  <= '0;
            count_q       <= '0;
        end else if (state == RUN) begin
            assert ((set_mask & retire_mask) == '0)
                else $error("retire_stage: completion on an index retiring this cycle");
            head    <= head + RB'(n_ret);
            count_q <= count_q + 64'(n_ret);
            // A retiring mispredict squashes everything younger, including same-cycle completions.
            if (flush) begin
                complete_bits <= '0;
                mispred_bits  <= '0;
            end else begin
                complete_bits <= (complete_bits | set_mask) & ~retire_mask;
                mispred_bits  <= (mispred_bits | set_mp_mask) & ~retire_mask;
            end
            if (halt_hit) state <= HALTED;
        end
    end

    assign bus.num_retiring     = n_ret;
    assign bus.mispredict_flush = flush;
    assign bus.free_valid       = free_v;
    assign bus.free_preg        = free_p;
    assign bus.amt_valid        = amt_v;
    assign bus.amt_arch         = amt_a;
    assign bus.amt_preg         = amt_p;
    assign bus.halted           = (state == HALTED) && !reset;
    assign bus.retired_count    = reset ? 64'd0 : count_q;
endmodule

// File: tb/tb_retire_stage.sv
// Bench for retire_stage: the bench plays the ROB and keeps an in-order commit model.
module tb_retire_stage;
    localparam int N         = 3;
    localparam int ROB_SZ    = 8;
    localparam int PHYS_BITS = 6;
    localparam int RB        = $clog2(ROB_SZ);
    localparam int SB        = $clog2(N + 1);

    typedef struct packed {
        logic                 halt;
        logic                 is_branch;
        logic [4:0]           arch;
        logic [PHYS_BITS-1:0] t_new;
        logic [PHYS_BITS-1:0] t_old;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    retire_if #(.N(N), .ROB_SZ(ROB_SZ), .PHYS_BITS(PHYS_BITS)) rif ();
    retire_stage #(.N(N), .ROB_SZ(ROB_SZ), .PHYS_BITS(PHYS_BITS)) dut (
        .clock(clock), .reset(reset), .bus(rif.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the ROB as a circular table plus per-slot done/mispredict flags.
    ent_t        rob_tab[ROB_SZ];
    bit          m_done[ROB_SZ];
    bit          m_mp[ROB_SZ];
    int          m_head, m_tail, m_occ;
    bit          m_halted;
    longint      m_cnt;

    task automatic model_reset();
        m_head = 0; m_tail = 0; m_occ = 0; m_halted = 0; m_cnt = 0;
        for (int i = 0; i < ROB_SZ; i++) begin m_done[i] = 0; m_mp[i] = 0; end
    endtask

    task automatic dispatch(input bit h, input bit b, input int a, input int tn, input int to);
        rob_tab[m_tail] = '{h, b, 5'(a), PHYS_BITS'(tn), PHYS_BITS'(to)};
        m_tail = (m_tail + 1) % ROB_SZ;
        m_occ++;
    endtask

    task automatic drive_window();
        int nv;
        logic [31:0] r;
        ent_t e;
        nv = (m_occ < N) ? m_occ : N;
        rif.rob_outputs_valid = SB'(nv);
        for (int k = 0; k < N; k++) begin
            r = $urandom;
            e = (k < nv) ? rob_tab[(m_head + k) % ROB_SZ] : r[$bits(ent_t)-1:0];
            rif.rob_outputs[k].halt      = e.halt;
            rif.rob_outputs[k].is_branch = e.is_branch;
            rif.rob_outputs[k].arch_dest = e.arch;
            rif.rob_outputs[k].t_new     = e.t_new;
            rif.rob_outputs[k].t_old     = e.t_old;
        end
    endtask

    // One cycle: present the ROB window and completions, check outputs mid-cycle, advance the model.
    task automatic step(input logic [N-1:0] cv, input logic [N-1:0][RB-1:0] cidx, input logic [N-1:0] cmp);
        int nv, exp_n, ix;
        bit exp_flush, hit_halt, wr;
        ent_t e;
        drive_window();
        nv = int'(rif.rob_outputs_valid);
        rif.complete_valid      = cv;
        rif.complete_rob_idx    = cidx;
        rif.complete_mispredict = cmp;
        #2;
        exp_n = 0; exp_flush = 0; hit_halt = 0;
        if (!m_halted) begin
            for (int k = 0; k < nv; k++) begin
                ix = (m_head + k) % ROB_SZ;
                if (!m_done[ix]) break;
                exp_n++;
                if (m_mp[ix]) exp_flush = 1;
                if (rob_tab[ix].halt) hit_halt = 1;
                if (m_mp[ix] || rob_tab[ix].halt) break;
            end
        end
        vectors++;
        if (rif.num_retiring !== SB'(exp_n)) begin
            miscompares++; $display("FAIL num_retiring got %0d exp %0d @%0t", rif.num_retiring, exp_n, $time);
        end
        vectors++;
        if (rif.mispredict_flush !== exp_flush) begin
            miscompares++; $display("FAIL mispredict_flush got %b exp %b @%0t", rif.mispredict_flush, exp_flush, $time);
        end
        vectors++;
        if (rif.halted !== m_halted) begin
            miscompares++; $display("FAIL halted got %b exp %b @%0t", rif.halted, m_halted, $time);
        end
        vectors++;
        if (rif.retired_count !== 64'(m_cnt)) begin
            miscompares++; $display("FAIL retired_count got %0d exp %0d @%0t", rif.retired_count, m_cnt, $time);
        end
        for (int k = 0; k < N; k++) begin
            e  = rob_tab[(m_head + k) % ROB_SZ];
            wr = (k < exp_n) && (e.arch != 5'd0);
            vectors++;
            if (rif.free_valid[k] !== wr || rif.amt_valid[k] !== wr) begin
                miscompares++;
                $display("FAIL lane%0d strobes got free=%b amt=%b exp %b @%0t", k, rif.free_valid[k], rif.amt_valid[k], wr, $time);
            end
            if (wr) begin
                vectors++;
                if (rif.free_preg[k] !== e.t_old || rif.amt_preg[k] !== e.t_new || rif.amt_arch[k] !== e.arch) begin
                    miscompares++;
                    $display("FAIL lane%0d data got free=%0d amt=%0d/%0d exp %0d %0d/%0d", k,
                             rif.free_preg[k], rif.amt_arch[k], rif.amt_preg[k], e.t_old, e.arch, e.t_new);
                end
            end else if (k >= exp_n) begin
                vectors++;
                if (rif.free_preg[k] !== '0 || rif.amt_preg[k] !== '0 || rif.amt_arch[k] !== '0) begin
                    miscompares++;
                    $display("FAIL lane%0d idle data got %0d %0d/%0d exp 0", k, rif.free_preg[k], rif.amt_arch[k], rif.amt_preg[k]);
                end
            end
        end
        @(posedge clock); #1;
        if (!m_halted) begin
            for (int k = 0; k < exp_n; k++) begin
                ix = (m_head + k) % ROB_SZ; m_done[ix] = 0; m_mp[ix] = 0;
            end
            m_head = (m_head + exp_n) % ROB_SZ;
            m_occ -= exp_n;
            m_cnt += exp_n;
            if (hit_halt) m_halted = 1;
            if (exp_flush) begin
                for (int i = 0; i < ROB_SZ; i++) begin m_done[i] = 0; m_mp[i] = 0; end
                m_occ = 0; m_tail = m_head;
            end else begin
                for (int k = 0; k < N; k++)
                    if (cv[k]) begin
                        m_done[cidx[k]] = 1;
                        if (cmp[k]) m_mp[cidx[k]] = 1;
                    end
            end
        end
    endtask

    task automatic idle();
        step('0, '0, '0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rif.rob_outputs_valid   = SB'(N);
        rif.complete_valid      = '1;
        rif.complete_rob_idx    = {RB'(2), RB'(1), RB'(0)};
        rif.complete_mispredict = '1;
        for (int k = 0; k < N; k++) rif.rob_outputs[k] = $urandom;
        @(posedge clock); #1; @(posedge clock); #2;
        vectors++;
        if (rif.num_retiring !== '0 || rif.free_valid !== '0 || rif.amt_valid !== '0 ||
            rif.mispredict_flush !== 1'b0 || rif.halted !== 1'b0 || rif.retired_count !== 64'd0 ||
            rif.free_preg !== '0 || rif.amt_preg !== '0 || rif.amt_arch !== '0) begin
            miscompares++;
            $display("FAIL reset outputs got n=%0d fv=%b av=%b fl=%b h=%b cnt=%0d exp all 0", rif.num_retiring,
                     rif.free_valid, rif.amt_valid, rif.mispredict_flush, rif.halted, rif.retired_count);
        end
        reset = 1'b0;
        rif.complete_valid = '0;
        model_reset();
    endtask

    task automatic test_basic();
        dispatch(0, 0, 1, 33, 1); dispatch(0, 0, 2, 34, 2); dispatch(0, 0, 3, 35, 3);
        step(3'b111, {RB'(2), RB'(1), RB'(0)}, '0);
        idle();   // all three retire
        idle();   // count now 3
    endtask

    task automatic test_in_order();
        int a;
        a = m_tail;
        dispatch(0, 0, 4, 40, 20); dispatch(0, 0, 5, 41, 21);
        step(3'b001, {RB'(0), RB'(0), RB'(a + 1)}, '0);
        idle(); idle();
        step(3'b001, {RB'(0), RB'(0), RB'(a)}, '0);
        idle(); idle();
    endtask

    task automatic test_mispredict();
        test_reset();
        dispatch(0, 1, 6, 42, 22); dispatch(0, 0, 7, 43, 23); dispatch(0, 0, 8, 44, 24);
        step(3'b111, {RB'(2), RB'(1), RB'(0)}, 3'b001);
        idle(); idle();
        // Reused slots must not inherit stale completion from the squashed entries.
        dispatch(0, 0, 9, 45, 25); dispatch(0, 0, 10, 46, 26);
        idle(); idle();
        step(3'b011, {RB'(0), RB'(m_head + 1), RB'(m_head)}, '0);
        idle(); idle();
    endtask

    task automatic run_to_head(input int target);
        int cyc;
        cyc = 0;
        while (m_head != target) begin
            if (cyc > 200) begin
                vectors++; miscompares++;
                $display("FAIL run_to_head timeout head %0d exp %0d", m_head, target);
                break;
            end
            if (m_occ == 0) dispatch(0, 0, $urandom_range(1, 31), $urandom, $urandom);
            if (!m_done[m_head]) step(3'b001, {RB'(0), RB'(0), RB'(m_head)}, '0);
            else idle();
            cyc++;
        end
    endtask

    task automatic test_wrap();
        test_reset();
        run_to_head(ROB_SZ - 1);
        dispatch(0, 0, 11, 47, 27); dispatch(0, 0, 12, 48, 28);
        step(3'b011, {RB'(0), RB'(0), RB'(ROB_SZ - 1)}, '0);
        idle();
        dispatch(0, 0, 13, 49, 29); dispatch(0, 0, 14, 50, 30);
        idle(); idle();
        step(3'b011, {RB'(0), RB'(2), RB'(1)}, '0);
        idle();
    endtask

    task automatic test_arch0();
        dispatch(0, 0, 0, 51, 31); dispatch(0, 0, 15, 52, 32);
        step(3'b011, {RB'(0), RB'(m_head + 1), RB'(m_head)}, '0);
        idle(); idle();
    endtask

    task automatic test_halt();
        test_reset();
        dispatch(0, 0, 1, 33, 1); dispatch(1, 0, 0, 0, 0); dispatch(0, 0, 3, 35, 3); dispatch(0, 0, 4, 36, 4);
        step(3'b111, {RB'(2), RB'(1), RB'(0)}, '0);
        idle();
        step(3'b001, {RB'(0), RB'(0), RB'(3)}, '0);
        idle(); idle();
        test_reset();
        idle();
    endtask

    task automatic test_random();
        int cand[$];
        int p, nd, nc;
        logic [N-1:0] cv, cmp;
        logic [N-1:0][RB-1:0] ci;
        test_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (m_halted && $urandom_range(0, 5) == 0) test_reset();
            nd = $urandom_range(0, 2);
            for (int d = 0; d < nd; d++)
                if (m_occ < ROB_SZ)
                    dispatch($urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 31),
                             $urandom, $urandom);
            cand.delete();
            for (int j = 0; j < m_occ; j++)
                if (!m_done[(m_head + j) % ROB_SZ]) cand.push_back((m_head + j) % ROB_SZ);
            cv = '0; cmp = '0; ci = '0;
            nc = $urandom_range(0, N);
            for (int k = 0; k < nc && cand.size() > 0; k++) begin
                p = $urandom_range(0, cand.size() - 1);
                ci[k] = RB'(cand[p]);
                cv[k] = 1'b1;
                cmp[k] = rob_tab[cand[p]].is_branch && ($urandom_range(0, 2) == 0);
                cand.delete(p);
            end
            step(cv, ci, cmp);
        end
    endtask

    initial begin
        rif.rob_outputs = '0;
        rif.rob_outputs_valid = '0;
        rif.complete_valid = '0;
        rif.complete_rob_idx = '0;
        rif.complete_mispredict = '0;
        model_reset();
        test_reset();
        test_basic();
        test_in_order();
        test_arch0();
        test_mispredict();
        test_wrap();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
